uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that serialises one 8-bit byte per request into a standard asynchronous frame: start bit, 8 data bits LSB first, optional even parity, and one stop bit. It is the transmit-side counterpart of the UART receive datapath and shares its frame format and bit-time convention. It sits between the bus-side UART register logic, which supplies bytes through a start/busy/done handshake, and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per bit time; legal range 2..1023.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_start`  in  1  request to send `tx_data`; sampled only in IDLE.
- `tx_data`  in  8  byte to transmit; captured on the accepting edge.
- `tx_out`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.
- `bit_cnto`  out  4  index of the current frame bit: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop when parity is enabled.

## Operation
- The FSM has five states: IDLE, START, DATA, PARITY and STOP.
- Reset, or rst asserted at any point mid-frame, forces the following on the next edge:
  - state = IDLE, `tx_out` = 1, `tx_busy` = 0, `tx_done` = 0, `bit_cnto` = 0;
  - the baud counter and shift register are cleared;
  - a partial frame is abandoned and no `tx_done` is generated for it.
- IDLE:
  - `tx_out` = 1.
  - When `tx_start` = 1, latch `tx_data` into the shift register, go to START, and set `tx_busy` = 1 and `tx_out` = 0.
  - With parity enabled, also compute parity = XOR of `tx_data` bits.
- START: hold `tx_out` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_cnto` = 1.
- DATA:
  - `tx_out` = shift register bit 0; hold for `CLKS_PER_BIT` cycles, then shift right.
  - After the 8th data bit, go to PARITY if `UART_TX_PARITY_EN` is defined, otherwise go to STOP.
- PARITY: `tx_out` = the stored parity bit for one bit time, then go to STOP.
- STOP:
  - `tx_out` = 1 for one bit time.
  - Then go to IDLE, with `tx_busy` = 0 and `tx_done` = 1 for exactly one cycle.
- Baud counter:
  - 10 bits wide; counts 0..`CLKS_PER_BIT`-1.
  - Wraps to 0 on the last count, and that wrap advances the bit.
  - It is reset to 0 whenever a frame is accepted.
- `tx_start` while `tx_busy` = 1 is ignored and is neither queued nor latched.
- A change on `tx_data` after acceptance has no effect on the frame in progress.

## Timing
- All outputs are registered, with no combinational path from input to output.
- `tx_start` is sampled high in IDLE at edge E. After E:
  - `tx_out` = 0 and `tx_busy` = 1.
  - The start bit occupies the `CLKS_PER_BIT` cycles following E.
- Frame length is F bits: F = 10 without parity, F = 11 with parity. The frame occupies cycles 1..F·`CLKS_PER_BIT` after E.
- In cycle F·`CLKS_PER_BIT`+1 after E:
  - `tx_done` = 1, `tx_busy` = 0, state = IDLE;
  - `tx_out` remains 1.
- Back-to-back transfer:
  - `tx_start` held high in the `tx_done` cycle is accepted in that cycle.
  - The next start bit follows immediately, with zero idle cycles beyond the stop bit.
- `bit_cnto` updates on the same edge as the corresponding `tx_out` transition.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - an even-parity bit is inserted between D7 and the stop bit;
  - frames are 11 bits long;
  - `bit_cnto` reaches 10.
- `UART_TX_PARITY_EN` undefined:
  - the PARITY state and parity register are not compiled;
  - frames are 10 bits long;
  - `bit_cnto` maximum is 9.

## Test plan
- Reset idle (`CLKS_PER_BIT`=4):
  - Stimulus: hold rst for 3 cycles with `tx_start`=1.
  - Required response: `tx_out`=1, `tx_busy`=0, `tx_done`=0 throughout, and no frame starts.
- Single byte, no parity (`CLKS_PER_BIT`=4):
  - Stimulus: send 0xA5.
  - Required response: `tx_out` sequence per bit is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `tx_done` pulses exactly once at cycle 41 after acceptance.
- Parity build (`UART_TX_PARITY_EN`, `CLKS_PER_BIT`=4):
  - 0xA5 → parity bit 0, frame length 44 cycles.
  - 0x07 → parity bit 1.
- Back-to-back: assert `tx_start` in the `tx_done` cycle with 0x3C.
  - Required response: the start bit begins on the next cycle.
  - Line bits are 0,0,0,1,1,1,1,0,0,1.
- Busy ignore:
  - Stimulus: pulse `tx_start` with 0xFF in the middle of a 0x00 frame.
  - Required response: the frame still carries 0x00, and there is no second frame.
- Reset mid-frame:
  - Stimulus: assert rst during D3 of a frame.
  - Required response: next cycle `tx_out`=1, `tx_busy`=0, no `tx_done`.
  - A subsequent 0x55 frame is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte handshake between the bus-side UART register logic and the transmitter.
`timescale 1ns/1ps
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frames).
`timescale 1ns/1ps
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx_out,
  output logic [3:0] bit_cnto
);

  localparam logic [9:0] LAST_CNT = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] baud_q, baud_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_q, bit_d;
  logic       out_q, out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  logic       last_cnt;
  assign last_cnt = (baud_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      out_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Every output is computed one cycle ahead so the line, busy, done and the
  // bit index all change on the same edge as the state they describe.
  always_comb begin
    state_d  = state_q;
    baud_d   = last_cnt ? '0 : baud_q + 10'd1;
    shift_d  = shift_q;
    bit_d    = bit_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        out_d  = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          shift_d  = bus.tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^bus.tx_data;
`endif
          state_d  = START;
          busy_d   = 1'b1;
          out_d    = 1'b0;
        end
      end

      START: begin
        if (last_cnt) begin
          state_d = DATA;
          bit_d   = 4'd1;
          out_d   = shift_q[0];
        end
      end

      DATA: begin
        if (last_cnt) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 4'd8) begin
            bit_d = 4'd9;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            out_d   = parity_q;
`else
            state_d = STOP;
            out_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
            out_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last_cnt) begin
          state_d = STOP;
          bit_d   = 4'd10;
          out_d   = 1'b1;
        end
      end
`endif

      STOP: begin
        if (last_cnt) begin
          state_d = IDLE;
          bit_d   = '0;
          out_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        out_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_out      = out_q;
  assign bit_cnto    = bit_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of queued bytes checked bit by bit on the line.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned F = 11;
`else
  localparam int unsigned F = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_out;
  logic [3:0] bit_cnto;

  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .tx_out   (tx_out),
    .bit_cnto (bit_cnto)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned frames_done = 0;
  int unsigned n_abort = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    b[9] = ^d;
`endif
    return b;
  endfunction

  // Called at the negedge of the first start-bit cycle.
  task automatic run_frame();
    logic [7:0]  d;
    logic [10:0] bits;
    check("sb_pending", (sb_q.size() > 0), 1);
    if (sb_q.size() == 0) begin
      for (int k = 0; k < F*CPB + 2 && tx_out !== 1'b1; k++) @(negedge clk);
      return;
    end
    d    = sb_q.pop_front();
    bits = frame_bits(d);
    for (int b = 0; b < F; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (rst) begin
          n_abort++;
          @(negedge clk);
          check("abort_line", tx_out, 1);
          check("abort_busy", bus.tx_busy, 0);
          check("abort_done", bus.tx_done, 0);
          check("abort_bitcnt", bit_cnto, 0);
          return;
        end
        check($sformatf("%02h_bit%0d_line", d, b), tx_out, bits[b]);
        if (c == 0) begin
          check($sformatf("%02h_bit%0d_cnt", d, b), bit_cnto, b);
          check($sformatf("%02h_bit%0d_busy", d, b), bus.tx_busy, 1);
          check($sformatf("%02h_bit%0d_done", d, b), bus.tx_done, 0);
        end
      end
    end
    @(negedge clk);
    check($sformatf("%02h_done_pulse", d), bus.tx_done, 1);
    check($sformatf("%02h_done_busy", d), bus.tx_busy, 0);
    check($sformatf("%02h_done_line", d), tx_out, 1);
    check($sformatf("%02h_done_cnt", d), bit_cnto, 0);
    frames_done++;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_out === 1'b0) run_frame();
        else check("idle_done", bus.tx_done, 0);
      end
    end
  end

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (bus.tx_busy !== 1'b0 && k < 4*F*CPB) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", (bus.tx_busy === 1'b0), 1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    wait_idle();
    @(posedge clk); #1;
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    sb_q.push_back(d);
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
  endtask

  initial begin : stimulus
    int unsigned k;
    rst          = 1'b1;
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hA5;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_line", tx_out, 1);
      check("rst_busy", bus.tx_busy, 0);
      check("rst_done", bus.tx_done, 0);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.tx_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_line", tx_out, 1);
      check("post_rst_busy", bus.tx_busy, 0);
    end

    send_byte(8'hA5);
    send_byte(8'h07);

    // Back-to-back: raise tx_start during the done pulse.
    k = 0;
    @(negedge clk);
    while (bus.tx_done !== 1'b1 && k < 2*F*CPB) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", bus.tx_done, 1);
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'h3C;
    sb_q.push_back(8'h3C);
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    @(negedge clk);
    check("b2b_start_line", tx_out, 0);
    check("b2b_start_busy", bus.tx_busy, 1);

    // Busy ignore: 0xFF request mid-frame must not be queued or latched.
    send_byte(8'h00);
    repeat (3*CPB) @(posedge clk);
    #1;
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hFF;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    wait_idle();
    repeat (2*F*CPB) @(negedge clk);

    // Reset during D3 (bit index 4).
    send_byte(8'h96);
    k = 0;
    @(negedge clk);
    while (bit_cnto !== 4'd4 && k < 10*CPB) begin
      @(negedge clk);
      k++;
    end
    check("d3_reached", bit_cnto, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2*F*CPB) @(negedge clk);

    send_byte(8'h55);
    wait_idle();
    repeat (2*F*CPB) @(negedge clk);

    check("sb_empty", sb_q.size(), 0);
    check("frames_done", frames_done, 5);
    check("aborts", n_abort, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
